// File: rtl/edm_pulse_generator.sv
// edm_pulse_generator: discharge gate pulse train driven by the SPI command
// decoder's Ton/Toff/Ip/start/stop outputs. Parameters are double-buffered
// (pending -> active) and applied only at period boundaries. The completed
// pulse count is returned on feedback_data / change_feedback_ack.
//
// Optional build macro EDM_TOFF_MIN_EN: when defined, the effective off-time
// is floored at TOFF_MIN units; otherwise only a zero off-time becomes 1 unit.
module edm_pulse_generator #(
  parameter int unsigned TICKS_PER_UNIT = 216,  // clk cycles per unit, >= 1
  parameter int unsigned TOFF_MIN       = 4     // off-time floor in units
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        machine_start_ack,
  input  logic        machine_stop_ack,
  input  logic [15:0] Ton_data,
  input  logic        change_Ton_ack,
  input  logic [15:0] Toff_data,
  input  logic        change_Toff_ack,
  input  logic [15:0] Ip_data,
  input  logic        change_Ip_ack,
  output logic        pulse_on,
  output logic [15:0] ip_setpoint,
  output logic        running,
  output logic        period_start,
  output logic [31:0] feedback_data,
  output logic        change_feedback_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  localparam logic [15:0] TON_RST  = 16'd80;
  localparam logic [15:0] TOFF_RST = 16'd20;
  localparam logic [15:0] IP_RST   = 16'd30;

  localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_UNIT - 1);

`ifdef EDM_TOFF_MIN_EN
  localparam bit TOFF_MIN_EN = 1'b1;
`else
  localparam bit TOFF_MIN_EN = 1'b0;
`endif

  // A single floor covers both the zero clamp and the optional TOFF_MIN clamp.
  localparam int unsigned TOFF_FLOOR_I = (TOFF_MIN_EN && (TOFF_MIN > 1)) ? TOFF_MIN : 1;
  localparam logic [15:0] TOFF_FLOOR   = 16'(TOFF_FLOOR_I);
  localparam logic [15:0] TON_FLOOR    = 16'd1;

  // Edge-detect copies of the acks
  logic start_q, stop_q, ton_ack_q, toff_ack_q, ip_ack_q;
  logic start_edge, stop_edge, ton_edge, toff_edge, ip_edge;

  // Pending (host-written) and active (in-use) parameter sets
  logic [15:0] ton_pend_q, ton_pend_d;
  logic [15:0] toff_pend_q, toff_pend_d;
  logic [15:0] ip_pend_q, ip_pend_d;
  logic [15:0] ton_act_q, ton_act_d;
  logic [15:0] toff_act_q, toff_act_d;
  logic [15:0] ip_act_q, ip_act_d;

  // Sequencer
  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] unit_q, unit_d;
  logic        ps_q, ps_d;
  logic [31:0] feedback_q, feedback_d;
  logic        fb_ack_q, fb_ack_d;

  logic        load_active;
  logic        count_period;
  logic [15:0] ton_eff;
  logic [15:0] toff_eff;
  logic [15:0] unit_last;
  logic        tick_last;
  logic        unit_done;

  assign start_edge = machine_start_ack & ~start_q;
  assign stop_edge  = machine_stop_ack  & ~stop_q;
  assign ton_edge   = change_Ton_ack    & ~ton_ack_q;
  assign toff_edge  = change_Toff_ack   & ~toff_ack_q;
  assign ip_edge    = change_Ip_ack     & ~ip_ack_q;

  // Effective phase lengths in units after clamping
  always_comb begin
    ton_eff  = (ton_act_q  < TON_FLOOR)  ? TON_FLOOR  : ton_act_q;
    toff_eff = (toff_act_q < TOFF_FLOOR) ? TOFF_FLOOR : toff_act_q;
  end

  // Terminal-count detection for the current phase
  always_comb begin
    unit_last = (state_q == S_ON) ? (ton_eff - 16'd1) : (toff_eff - 16'd1);
    tick_last = (presc_q == PRESC_LAST);
    unit_done = tick_last && (unit_q == unit_last);
  end

  // Next-state logic: phase sequencing, counters, boundary load, pulse count
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    unit_d       = unit_q;
    ps_d         = 1'b0;
    load_active  = 1'b0;
    count_period = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Stop has priority, so simultaneous start+stop leaves us idle.
        if (start_edge && !stop_edge) begin
          load_active = 1'b1;
          presc_d     = '0;
          unit_d      = '0;
          ps_d        = 1'b1;
          state_d     = S_ON;
        end
      end

      S_ON: begin
        if (stop_edge) begin
          presc_d = '0;
          unit_d  = '0;
          state_d = S_IDLE;
        end else if (tick_last) begin
          presc_d = '0;
          if (unit_done) begin
            unit_d  = '0;
            state_d = S_OFF;
          end else begin
            unit_d = unit_q + 16'd1;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end

      S_OFF: begin
        if (stop_edge) begin
          presc_d = '0;
          unit_d  = '0;
          state_d = S_IDLE;
        end else if (tick_last) begin
          presc_d = '0;
          if (unit_done) begin
            unit_d       = '0;
            count_period = 1'b1;
            load_active  = 1'b1;
            ps_d         = 1'b1;
            state_d      = S_ON;
          end else begin
            unit_d = unit_q + 16'd1;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end

      default: begin
        presc_d = '0;
        unit_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Parameter capture (pending) and boundary application (active)
  always_comb begin
    ton_pend_d  = ton_edge  ? Ton_data  : ton_pend_q;
    toff_pend_d = toff_edge ? Toff_data : toff_pend_q;
    ip_pend_d   = ip_edge   ? Ip_data   : ip_pend_q;
    // Active copies take the pre-edge pending value, so a change landing on
    // a boundary cycle waits for the following boundary.
    ton_act_d   = load_active ? ton_pend_q  : ton_act_q;
    toff_act_d  = load_active ? toff_pend_q : toff_act_q;
    ip_act_d    = load_active ? ip_pend_q   : ip_act_q;
    feedback_d  = count_period ? (feedback_q + 32'd1) : feedback_q;
    fb_ack_d    = count_period;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      ton_ack_q   <= 1'b0;
      toff_ack_q  <= 1'b0;
      ip_ack_q    <= 1'b0;
      ton_pend_q  <= TON_RST;
      toff_pend_q <= TOFF_RST;
      ip_pend_q   <= IP_RST;
      ton_act_q   <= TON_RST;
      toff_act_q  <= TOFF_RST;
      ip_act_q    <= IP_RST;
      state_q     <= S_IDLE;
      presc_q     <= '0;
      unit_q      <= '0;
      ps_q        <= 1'b0;
      feedback_q  <= '0;
      fb_ack_q    <= 1'b0;
    end else begin
      start_q     <= machine_start_ack;
      stop_q      <= machine_stop_ack;
      ton_ack_q   <= change_Ton_ack;
      toff_ack_q  <= change_Toff_ack;
      ip_ack_q    <= change_Ip_ack;
      ton_pend_q  <= ton_pend_d;
      toff_pend_q <= toff_pend_d;
      ip_pend_q   <= ip_pend_d;
      ton_act_q   <= ton_act_d;
      toff_act_q  <= toff_act_d;
      ip_act_q    <= ip_act_d;
      state_q     <= state_d;
      presc_q     <= presc_d;
      unit_q      <= unit_d;
      ps_q        <= ps_d;
      feedback_q  <= feedback_d;
      fb_ack_q    <= fb_ack_d;
    end
  end

  assign pulse_on            = (state_q == S_ON);
  assign running             = (state_q != S_IDLE);
  assign period_start        = ps_q;
  assign ip_setpoint         = ip_act_q;
  assign feedback_data       = feedback_q;
  assign change_feedback_ack = fb_ack_q;

endmodule

// File: tb/tb_edm_pulse_generator.sv
// Directed bench for edm_pulse_generator with a scoreboard of expected
// per-period ON/OFF lengths, Ip setpoints and feedback counts.
module tb_edm_pulse_generator;

  localparam int unsigned TPU         = 4;
  localparam int unsigned TOFF_MIN_TB = 4;

  logic        clk;
  logic        rst;
  logic        machine_start_ack, machine_stop_ack;
  logic [15:0] Ton_data, Toff_data, Ip_data;
  logic        change_Ton_ack, change_Toff_ack, change_Ip_ack;
  logic        pulse_on, running, period_start, change_feedback_ack;
  logic [15:0] ip_setpoint;
  logic [31:0] feedback_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ip[$];
  logic [31:0] exp_on[$];
  logic [31:0] exp_off[$];
  logic [31:0] exp_fb[$];

  edm_pulse_generator #(
    .TICKS_PER_UNIT(TPU),
    .TOFF_MIN(TOFF_MIN_TB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .machine_start_ack(machine_start_ack),
    .machine_stop_ack(machine_stop_ack),
    .Ton_data(Ton_data),
    .change_Ton_ack(change_Ton_ack),
    .Toff_data(Toff_data),
    .change_Toff_ack(change_Toff_ack),
    .Ip_data(Ip_data),
    .change_Ip_ack(change_Ip_ack),
    .pulse_on(pulse_on),
    .ip_setpoint(ip_setpoint),
    .running(running),
    .period_start(period_start),
    .feedback_data(feedback_data),
    .change_feedback_ack(change_feedback_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_ton(input int units);
    return ((units < 1) ? 1 : units) * TPU;
  endfunction

  function automatic int exp_toff(input int units);
    int u;
    u = (units < 1) ? 1 : units;
`ifdef EDM_TOFF_MIN_EN
    if (u < TOFF_MIN_TB) u = TOFF_MIN_TB;
`endif
    return u * TPU;
  endfunction

  // Monitor: measures completed ON/OFF phases and strobes, compares to queue
  int  on_cnt = 0;
  int  off_cnt = 0;
  logic prev_on = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      on_cnt  = 0;
      off_cnt = 0;
      prev_on = 1'b0;
    end else begin
      if (pulse_on && !prev_on) chk("period_start_on_rise", period_start, 1);
      if (period_start) begin
        if (exp_ip.size() == 0) chk("period_start_unexpected", period_start, 0);
        else chk("ip_setpoint", ip_setpoint, exp_ip.pop_front());
      end
      if (pulse_on) begin
        if (period_start) begin
          if (off_cnt != 0) begin
            if (exp_off.size() == 0) chk("off_unexpected", off_cnt, 0);
            else chk("off_len", off_cnt, exp_off.pop_front());
          end
          on_cnt  = 0;
          off_cnt = 0;
        end
        on_cnt++;
      end else if (running) begin
        if (on_cnt != 0) begin
          if (exp_on.size() == 0) chk("on_unexpected", on_cnt, 0);
          else chk("on_len", on_cnt, exp_on.pop_front());
          on_cnt = 0;
        end
        off_cnt++;
      end else begin
        on_cnt  = 0;
        off_cnt = 0;
      end
      if (change_feedback_ack) begin
        if (exp_fb.size() == 0) chk("fb_unexpected", change_feedback_ack, 0);
        else chk("feedback_data", feedback_data, exp_fb.pop_front());
      end
      prev_on = pulse_on;
    end
  end

  task automatic start_pulse(input int n);
    @(negedge clk);
    machine_start_ack = 1'b1;
    repeat (n) @(negedge clk);
    machine_start_ack = 1'b0;
  endtask

  task automatic write_reg(input int which, input logic [15:0] v);
    @(negedge clk);
    case (which)
      0: begin Ton_data = v;  change_Ton_ack = 1'b1;  end
      1: begin Toff_data = v; change_Toff_ack = 1'b1; end
      default: begin Ip_data = v; change_Ip_ack = 1'b1; end
    endcase
    repeat (3) @(negedge clk);
    change_Ton_ack  = 1'b0;
    change_Toff_ack = 1'b0;
    change_Ip_ack   = 1'b0;
  endtask

  task automatic wait_fb(input logic [31:0] v, input int budget);
    int n;
    n = 0;
    while (!(change_feedback_ack === 1'b1 && feedback_data === v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_fb_timeout", (n < budget), 1);
  endtask

  task automatic wait_off(input int budget);
    int n;
    n = 0;
    while (!(running === 1'b1 && pulse_on === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_off_timeout", (n < budget), 1);
  endtask

  // Stop edge, then check that the block is idle one cycle later
  task automatic stop_and_check(input logic [31:0] fb_exp);
    machine_stop_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("stop_pulse_on", pulse_on, 0);
    chk("stop_running", running, 0);
    chk("stop_feedback", feedback_data, fb_exp);
    repeat (4) @(negedge clk);
    machine_stop_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    machine_start_ack = 1'b0;
    machine_stop_ack  = 1'b0;
    Ton_data = '0; Toff_data = '0; Ip_data = '0;
    change_Ton_ack = 1'b0; change_Toff_ack = 1'b0; change_Ip_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pulse_on", pulse_on, 0);
    chk("rst_running", running, 0);
    chk("rst_period_start", period_start, 0);
    chk("rst_fb_ack", change_feedback_ack, 0);
    chk("rst_feedback", feedback_data, 0);
    chk("rst_ip", ip_setpoint, 30);
    rst = 1'b0;

    // Periods 1..3: defaults, then Ton=3/Toff=2/Ip=55 written mid-ON
    exp_ip.push_back(30); exp_on.push_back(exp_ton(80)); exp_off.push_back(exp_toff(20)); exp_fb.push_back(1);
    exp_ip.push_back(55); exp_on.push_back(exp_ton(3));  exp_off.push_back(exp_toff(2));  exp_fb.push_back(2);
    exp_ip.push_back(55); exp_on.push_back(exp_ton(3));
    start_pulse(7);
    write_reg(0, 16'd9);
    write_reg(0, 16'd3);
    write_reg(1, 16'd2);
    write_reg(2, 16'd55);
    chk("ip_hold_mid_on", ip_setpoint, 30);
    chk("still_on", pulse_on, 1);
    wait_fb(32'd1, 1000);
    chk("ip_after_boundary", ip_setpoint, 55);
    wait_fb(32'd2, 200);
    @(negedge clk);
    wait_off(200);
    stop_and_check(32'd2);

    // Restart uses current pending values; stop during ON of the next period
    exp_ip.push_back(55); exp_on.push_back(exp_ton(3)); exp_off.push_back(exp_toff(2)); exp_fb.push_back(3);
    exp_ip.push_back(55);
    start_pulse(7);
    wait_fb(32'd3, 200);
    repeat (3) @(negedge clk);
    stop_and_check(32'd3);

    // Start and stop rising together from idle
    @(negedge clk);
    machine_start_ack = 1'b1;
    machine_stop_ack  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("both_running", running, 0);
    end
    machine_start_ack = 1'b0;
    machine_stop_ack  = 1'b0;

    // Zero Ton/Toff are clamped
    write_reg(0, 16'd0);
    write_reg(1, 16'd0);
    write_reg(2, 16'd7);
    exp_ip.push_back(7); exp_on.push_back(exp_ton(0)); exp_off.push_back(exp_toff(0)); exp_fb.push_back(4);
    exp_ip.push_back(7);
    start_pulse(3);
    wait_fb(32'd4, 200);
    repeat (2) @(negedge clk);
    stop_and_check(32'd4);

    // Feedback counter wrap
    force dut.feedback_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.feedback_q;
    @(negedge clk);
    chk("fb_preset", feedback_data, 32'hFFFF_FFFF);
    exp_ip.push_back(7); exp_on.push_back(exp_ton(0)); exp_off.push_back(exp_toff(0)); exp_fb.push_back(0);
    exp_ip.push_back(7);
    start_pulse(3);
    wait_fb(32'd0, 200);
    chk("fb_wrapped", feedback_data, 0);

    // Reset mid-ON
    @(negedge clk);
    chk("on_before_rst", pulse_on, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_pulse_on", pulse_on, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_period_start", period_start, 0);
    chk("mid_rst_fb_ack", change_feedback_ack, 0);
    chk("mid_rst_feedback", feedback_data, 0);
    chk("mid_rst_ip", ip_setpoint, 30);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("ip_queue_left", exp_ip.size(), 0);
    chk("on_queue_left", exp_on.size(), 0);
    chk("off_queue_left", exp_off.size(), 0);
    chk("fb_queue_left", exp_fb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
